// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep checker: FSM state encoding,
// reference-function codes and the reference evaluation function.
package gate_sweep_pkg;

    localparam int unsigned MAX_IN = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam int unsigned FUNC_OR  = 0;
    localparam int unsigned FUNC_AND = 1;
    localparam int unsigned FUNC_XOR = 2;
    localparam int unsigned FUNC_NOR = 3;

    // Expected gate output for an n-input vector (zero-extended to MAX_IN bits).
    // Unknown function codes evaluate to 0.
    function automatic logic ref_eval(input int unsigned func,
                                      input logic [MAX_IN-1:0] vec,
                                      input int unsigned n);
        logic [MAX_IN:0] mask;
        mask = (7'(1) << n) - 7'(1);
        case (func)
            FUNC_OR:  return |vec;
            FUNC_AND: return vec == mask[MAX_IN-1:0];
            FUNC_XOR: return ^vec;
            FUNC_NOR: return ~|vec;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/gate_sweep_ref.sv
// Combinational reference model: expected gate output for the driven vector.
// Ports: vec - vector currently driven to the gate; exp_c - expected output.
module gate_sweep_ref
    import gate_sweep_pkg::*;
#(
    parameter int unsigned N_IN = 2,
    parameter int unsigned FUNC = 0
) (
    input  logic [N_IN-1:0] vec,
    output logic            exp_c
);

    assign exp_c = ref_eval(FUNC, MAX_IN'(vec), N_IN);

endmodule

// File: rtl/gate_sweep_checker.sv
// Self-driving response checker for an N_IN-input combinational gate.
// Sweeps every input vector, waits SETTLE cycles, samples the gate output and
// compares it with the reference function FUNC (0=OR,1=AND,2=XOR,3=NOR).
// Ports: clk, rst (async active-high), start, dut_in (driven vector),
//        dut_out (gate output), busy, done, pass, err_cnt, first_fail.
// Optional: define GATE_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first
//           mismatch, holding the failing vector on dut_in.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned FUNC   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail
);

    localparam int unsigned ERR_W = N_IN + 1;
    localparam int unsigned CNT_W = $clog2(SETTLE + 1);

    if (FUNC > 3) begin : g_bad_func
        $error("gate_sweep_checker: FUNC must be 0..3");
    end

    sweep_state_t    state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [N_IN-1:0] dut_in_n, first_fail_n;
    logic [N_IN:0]   err_cnt_n;
    logic            busy_n, done_n, pass_n;
    logic            exp_c;
    logic            mismatch_c;
    logic            last_vec_c;
    logic            finish_c;

    gate_sweep_ref #(.N_IN(N_IN), .FUNC(FUNC)) u_ref (
        .vec   (dut_in),
        .exp_c (exp_c)
    );

    assign mismatch_c = dut_out ^ exp_c;
    assign last_vec_c = (dut_in == '1);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    assign finish_c = last_vec_c | mismatch_c;
`else
    assign finish_c = last_vec_c;
`endif

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            dut_in     <= dut_in_n;
            busy       <= busy_n;
            done       <= done_n;
            pass       <= pass_n;
            err_cnt    <= err_cnt_n;
            first_fail <= first_fail_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        dut_in_n     = dut_in;
        busy_n       = busy;
        done_n       = done;
        pass_n       = pass;
        err_cnt_n    = err_cnt;
        first_fail_n = first_fail;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n      = WAIT;
                    cnt_n        = CNT_W'(SETTLE);
                    dut_in_n     = '0;
                    err_cnt_n    = '0;
                    first_fail_n = '0;
                    busy_n       = 1'b1;
                    done_n       = 1'b0;
                    pass_n       = 1'b0;
                end
            end
            WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch_c) begin
                    err_cnt_n = err_cnt + ERR_W'(1);
                    if (err_cnt == '0) begin
                        first_fail_n = dut_in;
                    end
                end
                if (finish_c) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_cnt_n == '0);
                end else begin
                    state_n  = WAIT;
                    dut_in_n = dut_in + N_IN'(1);
                    cnt_n    = CNT_W'(SETTLE);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
- Self-driving response checker for small combinational gates such as the team's 2-input OR cell.
- Drives every input combination of an N-input gate under test and waits a programmable settle time.
- Samples the gate output and compares it against a built-in reference function.
- Reports mismatch count, first failing vector and a pass/done status. It is the reading and judging end of the gate stimulus interface.

Parameters:
N_IN, 2, number of gate inputs driven (1..6)
SETTLE, 2, cycles between driving a vector and sampling (>=1)
FUNC, 0, reference function: 0=OR, 1=AND, 2=XOR, 3=NOR

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a sweep; sampled only in IDLE or DONE
dut_in  output  N_IN  vector driven to the gate under test
dut_out  input  1  gate-under-test output
busy  output  1  sweep in progress
done  output  1  sweep finished; held until next start or reset
pass  output  1  done and zero mismatches
err_cnt  output  N_IN+1  number of mismatching vectors
first_fail  output  N_IN  first vector that mismatched; valid when err_cnt!=0

Behaviour:
- Reset values: state=IDLE; dut_in=0; busy=0; done=0; pass=0; err_cnt=0; first_fail=0; settle counter=0.
- IDLE: on start=1, go to WAIT. On the same edge: dut_in=0, counter=SETTLE, err_cnt=0, first_fail=0, busy=1.
- WAIT: counter decrements each cycle. After SETTLE cycles in WAIT, go to SAMPLE.
- SAMPLE (1 cycle): compare dut_out with exp = FUNC applied to dut_in.
  - On mismatch, err_cnt increments. If err_cnt was 0, first_fail=dut_in.
  - If dut_in == 2^N_IN-1, go to DONE.
  - Otherwise dut_in increments, counter=SETTLE, back to WAIT.
- DONE: busy=0, done=1, pass=(err_cnt==0). A start restarts exactly as from IDLE and clears done/pass on the same edge.
- Latency: done rises 2^N_IN*(SETTLE+1) clock edges after the start edge (12 for defaults).
- start while busy: ignored, no restart.
- err_cnt is N_IN+1 bits, so it cannot overflow (max 2^N_IN); no saturation logic.
- dut_in changes only on the edge leaving SAMPLE, never during WAIT, so the gate sees stable inputs for SETTLE+1 cycles.
- rst asserted mid-sweep: all state returns to reset values immediately (asynchronous); no partial result retained.
- FUNC outside 0..3: exp=0; flagged by an elaboration-time check.

Optional Feature:
- Macro GATE_SWEEP_STOP_ON_FAIL_EN.
- When defined: the first mismatch in SAMPLE goes directly to DONE (pass=0, err_cnt=1, first_fail=failing vector), and dut_in holds the failing vector.
- When undefined: the full sweep always completes and err_cnt counts all mismatches.

Decomposition:
- Package gate_sweep_pkg holds:
  - the state encoding (IDLE, WAIT, SAMPLE, DONE);
  - FUNC code constants FUNC_OR/FUNC_AND/FUNC_XOR/FUNC_NOR;
  - the function ref_eval(func, vec) returning the expected bit.
- One sub-module is natural: gate_sweep_ref. It is a purely combinational reference model taking dut_in and producing exp, instantiated once.
- FSM, counters and result registers live in gate_sweep_checker.

Test Plan:
- Correct OR gate attached, defaults, pulse start -> dut_in steps 00,01,10,11; done=1 exactly 12 cycles after start; err_cnt=0; pass=1.
- Stuck-at-0 gate (dut_out=0), FUNC=0 -> err_cnt=3, first_fail=2'b01, pass=0, done=1.
- OR gate attached with FUNC=1 (AND reference) -> err_cnt=2 (vectors 01,10), first_fail=2'b01, pass=0.
- Assert rst at cycle 5 of a sweep -> all outputs return to reset values asynchronously. A new start then yields a clean full sweep with pass=1.
- start pulsed at cycles 3 and 7 while busy -> ignored, done still at cycle 12. start in DONE -> done/pass drop on that edge and a new sweep runs.
- With GATE_SWEEP_STOP_ON_FAIL_EN and stuck-at-0 gate -> done after 6 cycles, err_cnt=1, first_fail=2'b01, dut_in held at 2'b01.
